// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state type and parameter legality limits for the sequence detector
package seq_detect_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;
  function automatic bit params_ok(input int pat_len, input int cnt_w);
    return pat_len >= PAT_LEN_MIN && pat_len <= PAT_LEN_MAX &&
           cnt_w >= CNT_W_MIN && cnt_w <= CNT_W_MAX;
  endfunction
endpackage

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: clearable up-counter that sticks at all ones instead of wrapping
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = &cnt;
  // clear has priority; increments stop once the counter is full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-pattern serial sequence detector with saturating match counter
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               busy,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  if (!params_ok(PAT_LEN, CNT_W)) begin : g_bad_params
    $error("seq_detect_param: PAT_LEN or CNT_W out of range");
  end
  state_e             state, state_n;
  logic [PAT_LEN-1:0] pat_q, hist, hist_n;
  logic [FW-1:0]      fill, fill_n;
  logic               take, hit;
  assign busy = (state == RUN);
  // next state and shift/compare; a bit coinciding with start or stop is dropped
  always_comb begin
    state_n = start ? RUN : stop ? IDLE : state;
    take    = (state == RUN) && in_valid && !start && !stop;
    hist_n  = {hist[PAT_LEN-2:0], in_bit};
    fill_n  = (fill == FULL) ? FULL : fill + 1'b1;
    hit     = take && (fill_n == FULL) && (hist_n == pat_q);
  end
  // control state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // pattern latch, history, fill level and the one-cycle match pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat_q        <= '0;
      hist         <= '0;
      fill         <= '0;
      seq_detected <= 1'b0;
    end else begin
      seq_detected <= hit;
      if (start) begin
        pat_q <= pattern;
        hist  <= '0;
        fill  <= '0;
      end else if (take) begin
        hist <= hist_n;
        fill <= (hit && !OVERLAP) ? '0 : fill_n;
      end
    end
  seq_sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (hit),
    .cnt   (match_count),
    .sat   (count_sat)
  );
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench over three detector configurations sharing one stimulus
module tb_seq_detect_param;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic [2:0] pat3 = 3'b000;
  logic [1:0] pat2 = 2'b11;
  logic busy0, det0, sat0, busy1, det1, sat1, busy2, det2, sat2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic s, p, v, b;
    logic [2:0] pt;
    logic d, bz, st;
    logic [31:0] c;
  } row_t;
  row_t rows[$];
  logic [34:0] sb[$];
  always #5 clk = ~clk;
  seq_detect_param #(.PAT_LEN(3), .CNT_W(8), .OVERLAP(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pat3), .in_valid(in_valid),
    .in_bit(in_bit), .busy(busy0), .seq_detected(det0), .match_count(cnt0), .count_sat(sat0));
  seq_detect_param #(.PAT_LEN(3), .CNT_W(8), .OVERLAP(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pat3), .in_valid(in_valid),
    .in_bit(in_bit), .busy(busy1), .seq_detected(det1), .match_count(cnt1), .count_sat(sat1));
  seq_detect_param #(.PAT_LEN(2), .CNT_W(2), .OVERLAP(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pat2), .in_valid(in_valid),
    .in_bit(in_bit), .busy(busy2), .seq_detected(det2), .match_count(cnt2), .count_sat(sat2));
  function automatic logic [34:0] obs(input int u);
    case (u)
      0: return {det0, busy0, sat0, 32'(cnt0)};
      1: return {det1, busy1, sat1, 32'(cnt1)};
      default: return {det2, busy2, sat2, 32'(cnt2)};
    endcase
  endfunction
  function automatic string fmt(input logic [34:0] v);
    return $sformatf("det=%0b busy=%0b sat=%0b cnt=%0d", v[34], v[33], v[32], v[31:0]);
  endfunction
  task automatic add(input logic s, p, v, b, input logic [2:0] pt, input logic d, bz, st, input int c);
    rows.push_back('{s, p, v, b, pt, d, bz, st, 32'(c)});
  endtask
  task automatic apply(input row_t r);
    start = r.s; stop = r.p; in_valid = r.v; in_bit = r.b; pat3 = r.pt;
    sb.push_back({r.d, r.bz, r.st, r.c});
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (obs(u) !== 35'd0) begin
          errors++;
          $display("FAIL reset unit%0d pass%0d got %s want all zero", u, k, fmt(obs(u)));
        end
      end
      start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      rst_n = 1'b1;
    end
  endtask
  task automatic test_overlap;
    logic [34:0] e, o;
    rows.delete();
    add(1,0,0,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 0,1,0,0);
    add(0,0,1,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 1,1,0,1);
    add(0,0,1,0,3'b101, 0,1,0,1);
    add(0,0,1,1,3'b101, 1,1,0,2);
    add(0,1,1,1,3'b101, 0,0,0,2);
    add(0,0,1,1,3'b101, 0,0,0,2);
    add(0,0,1,0,3'b101, 0,0,0,2);
    add(0,0,1,1,3'b101, 0,0,0,2);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overlap step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  task automatic test_nonoverlap;
    logic [34:0] e, o;
    rows.delete();
    add(1,0,0,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 0,1,0,0);
    add(0,0,1,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 1,1,0,1);
    add(0,0,1,0,3'b101, 0,1,0,1);
    add(0,0,1,1,3'b101, 0,1,0,1);
    add(0,0,1,1,3'b101, 0,1,0,1);
    add(0,0,1,0,3'b101, 0,1,0,1);
    add(0,0,1,1,3'b101, 1,1,0,2);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(1); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nonoverlap step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  task automatic test_gaps;
    logic [34:0] e, o;
    rows.delete();
    add(1,0,0,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 0,1,0,0);
    add(0,0,0,1,3'b101, 0,1,0,0);
    add(0,0,1,0,3'b101, 0,1,0,0);
    add(0,0,0,1,3'b101, 0,1,0,0);
    add(0,0,0,1,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 1,1,0,1);
    add(0,0,0,1,3'b101, 0,1,0,1);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gaps step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  task automatic test_saturate;
    logic [34:0] e, o;
    rows.delete();
    add(1,0,0,0,3'b000, 0,1,0,0);
    add(0,0,1,1,3'b000, 0,1,0,0);
    add(0,0,1,1,3'b000, 1,1,0,1);
    add(0,0,1,1,3'b000, 1,1,0,2);
    add(0,0,1,1,3'b000, 1,1,1,3);
    add(0,0,1,1,3'b000, 1,1,1,3);
    add(0,0,1,1,3'b000, 1,1,1,3);
    add(0,0,0,1,3'b000, 0,1,1,3);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(2); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  task automatic test_stop_idle;
    logic [34:0] e, o;
    rows.delete();
    add(1,0,0,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 0,1,0,0);
    add(0,0,1,0,3'b101, 0,1,0,0);
    add(0,1,0,0,3'b101, 0,0,0,0);
    add(0,0,1,1,3'b101, 0,0,0,0);
    add(1,0,0,0,3'b110, 0,1,0,0);
    add(0,0,1,1,3'b000, 0,1,0,0);
    add(0,0,1,1,3'b000, 0,1,0,0);
    add(0,0,1,0,3'b000, 1,1,0,1);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_idle step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  task automatic test_async_reset;
    logic [34:0] e, o;
    rows.delete();
    add(0,0,1,1,3'b000, 0,1,0,1);
    add(0,0,1,0,3'b000, 0,1,0,1);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset pre step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
    in_valid = 1'b1; in_bit = 1'b1;
    rst_n = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obs(u) !== 35'd0) begin
        errors++;
        $display("FAIL async_reset unit%0d got %s want all zero", u, fmt(obs(u)));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (obs(0) !== 35'd0) begin
      errors++;
      $display("FAIL async_reset release got %s want all zero", fmt(obs(0)));
    end
    rows.delete();
    add(0,0,1,1,3'b101, 0,0,0,0);
    add(1,1,1,1,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 0,1,0,0);
    add(0,0,1,0,3'b101, 0,1,0,0);
    add(0,0,1,1,3'b101, 1,1,0,1);
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset post step%0d got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask
  initial begin
    #12;
    test_reset();
    @(posedge clk); #1;
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_saturate();
    test_stop_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
